// File: rtl/ex_stall_ctrl_pkg.sv
// Shared pipeline definitions for the execute-stage stall controller:
// multi-cycle unit state encoding, default latencies and the counter load helper.
package ex_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int MUL_LAT_DEFAULT = 4;
  localparam int DIV_LAT_DEFAULT = 32;
  localparam int CNT_W           = 6;

  // Busy-cycle count loaded at start; the final latency cycle is the MD_DONE cycle.
  function automatic logic [CNT_W-1:0] start_count(input logic is_div,
                                                   input int   mul_lat,
                                                   input int   div_lat);
    int lat;
    lat = is_div ? div_lat : mul_lat;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ex_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// source registers of the instruction in IF/ID.
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] if_rs,
  input  logic [4:0] if_rt,
  output logic       hazard
);

  assign hazard = mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == if_rs) || (ex_rt == if_rt));

endmodule

// File: rtl/ex_stall_ctrl.sv
// Execute-stage stall controller: load-use stalls plus multi-cycle mult/div
// occupancy. Optional stall performance counter enabled by EX_STALL_PERF_EN.
module ex_stall_ctrl
  import ex_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_ex_MemRead,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        flush,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_bubble,
  output logic        EX_hold,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hazard;

  hazard_detect u_hazard_detect (
    .mem_read (id_ex_MemRead),
    .ex_rt    (id_ex_rt),
    .if_rs    (if_id_rs),
    .if_rt    (if_id_rt),
    .hazard   (hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_bubble = 1'b0;
    EX_hold      = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (hazard) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
        if (md_start) begin
          state_next = MD_BUSY;
          cnt_next   = start_count(md_is_div, MUL_LAT, DIV_LAT);
        end
      end
      MD_BUSY: begin
        // ID/EX is frozen here, so md_start is a stale copy and is ignored.
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        EX_hold     = 1'b1;
        md_busy     = 1'b1;
        cnt_next    = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        md_done = 1'b1;
        if (hazard) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
        if (md_start) begin
          state_next = MD_BUSY;
          cnt_next   = start_count(md_is_div, MUL_LAT, DIV_LAT);
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

`ifdef EX_STALL_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (!PCWrite && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Scoreboard bench for ex_stall_ctrl: directed scenarios followed by random
// traffic, checked cycle by cycle against a latency-count reference model.
module tb_ex_stall_ctrl;
  localparam int MUL = 4;
  localparam int DIV = 32;

  logic        clk = 1'b0;
  logic        reset, id_ex_MemRead, md_start, md_is_div, flush;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic        PCWrite, IF_ID_Write, ID_EX_bubble, EX_hold, md_busy, md_done;
  logic [31:0] stall_cycles;

  typedef struct {
    bit          pc, ifid, bub, hold, busy, done;
    logic [31:0] stall;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: remaining busy cycles, a done-pulse flag and the stall count.
  int          busy_left = 0;
  bit          done_m    = 1'b0;
  logic [31:0] perf_m    = 32'd0;

  always #5 clk = ~clk;

  ex_stall_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clock        (clk),
    .reset        (reset),
    .id_ex_MemRead(id_ex_MemRead),
    .id_ex_rt     (id_ex_rt),
    .if_id_rs     (if_id_rs),
    .if_id_rt     (if_id_rt),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .flush        (flush),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .ID_EX_bubble (ID_EX_bubble),
    .EX_hold      (EX_hold),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("PCWrite", PCWrite, mon_e.pc);
      chk("IF_ID_Write", IF_ID_Write, mon_e.ifid);
      chk("ID_EX_bubble", ID_EX_bubble, mon_e.bub);
      chk("EX_hold", EX_hold, mon_e.hold);
      chk("md_busy", md_busy, mon_e.busy);
      chk("md_done", md_done, mon_e.done);
      chk("stall_cycles", stall_cycles, mon_e.stall);
    end
  end

  task automatic step(input bit rst_i, input bit fl_i, input bit st_i, input bit dv_i,
                      input bit ld_i, input logic [4:0] ert_i, input logic [4:0] rs_i,
                      input logic [4:0] rt_i);
    exp_t e;
    bit   hz, stalled;
    reset = rst_i; flush = fl_i; md_start = st_i; md_is_div = dv_i;
    id_ex_MemRead = ld_i; id_ex_rt = ert_i; if_id_rs = rs_i; if_id_rt = rt_i;
    hz      = ld_i && (ert_i != 0) && (ert_i == rs_i || ert_i == rt_i);
    e.busy  = (busy_left > 0);
    e.hold  = e.busy;
    e.done  = done_m;
    stalled = e.busy || hz;
    e.pc    = !stalled;
    e.ifid  = !stalled;
    e.bub   = !e.busy && hz;
`ifdef EX_STALL_PERF_EN
    e.stall = perf_m;
`else
    e.stall = 32'd0;
`endif
    exp_q.push_back(e);
    $display("cyc t=%0t rst=%0b fl=%0b st=%0b div=%0b ld=%0b rt=%0d rs=%0d/%0d exp_busy=%0b exp_done=%0b",
             $time, rst_i, fl_i, st_i, dv_i, ld_i, ert_i, rs_i, rt_i, e.busy, e.done);
    @(posedge clk);
    if (rst_i) begin
      busy_left = 0; done_m = 1'b0; perf_m = 32'd0;
    end else begin
      if (stalled && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 32'd1;
      if (fl_i) begin
        busy_left = 0; done_m = 1'b0;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
        done_m    = (busy_left == 0);
      end else begin
        done_m = 1'b0;
        if (st_i) busy_left = (dv_i ? DIV : MUL) - 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    id_ex_MemRead = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);   // reset-state check
    idle(1);
    // Load-use hazard for exactly one cycle, then a load to r0 that must not stall
    step(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9);
    step(0, 0, 0, 0, 1, 5'd5, 5'd7, 5'd9);
    step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    idle(1);
    // Multiply: three busy cycles then done
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(5);
    // Divide aborted by a flush at busy cycle 10
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(9);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(35);
    // Divide to completion with a back-to-back multiply started in the done cycle
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < DIV - 1; i++) step(0, 0, 1, 0, 1, 5'd3, 5'd3, 5'd0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(6);
    // Reset at busy cycle 2
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(5);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stall_ctrl.md
EX_STALL_CTRL -- requirements
Module: ex_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clock only.
REQ-002 Parameter MUL_LAT, default 4, SHALL set the multiply occupancy of the execute stage in cycles (legal range 2..63).
REQ-003 Parameter DIV_LAT, default 32, SHALL set the divide occupancy in cycles (legal range 2..63).
REQ-004 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- id_ex_MemRead  in  1  instruction in ID/EX is a load
- id_ex_rt  in  5  load destination register
- if_id_rs  in  5  rs of the instruction in IF/ID
- if_id_rt  in  5  rt of the instruction in IF/ID
- md_start  in  1  ID/EX holds a mult/div entering execute
- md_is_div  in  1  1 = divide, 0 = multiply (sampled with md_start)
- flush  in  1  taken branch, abort in-flight work
- PCWrite  out  1  0 = hold PC
- IF_ID_Write  out  1  0 = hold IF/ID
- ID_EX_bubble  out  1  1 = zero control signals into ID/EX
- EX_hold  out  1  1 = freeze ID/EX and EX/MEM inputs
- md_busy  out  1  multi-cycle op in progress
- md_done  out  1  one-cycle pulse, result valid
- stall_cycles  out  32  performance counter (see REQ-019)

Function
REQ-005 The FSM SHALL have states IDLE, MD_BUSY and MD_DONE, encoded in 2 bits.
REQ-006 In IDLE, md_start=1 SHALL load cnt with (md_is_div ? DIV_LAT : MUL_LAT) - 1 and move to MD_BUSY on the next edge.
REQ-007 In MD_BUSY, cnt SHALL decrement each cycle; when cnt==1, the next state SHALL be MD_DONE.
REQ-008 MD_DONE SHALL last exactly one cycle, assert md_done=1 and return to IDLE; md_start in MD_DONE SHALL start a new op (back-to-back).
REQ-009 Total occupancy from md_start to md_done SHALL equal the selected latency: MUL_LAT=4 gives md_done 4 cycles after the md_start edge.
REQ-010 The load-use hazard SHALL be combinational: id_ex_MemRead && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
REQ-011 Outputs in IDLE: a hazard SHALL drive PCWrite=0, IF_ID_Write=0 and ID_EX_bubble=1; with no hazard they SHALL be 1, 1 and 0.
REQ-012 In MD_BUSY: PCWrite=0, IF_ID_Write=0, EX_hold=1, md_busy=1 and ID_EX_bubble=0, regardless of the hazard.
REQ-013 In MD_DONE: EX_hold=0 and md_busy=0; PCWrite, IF_ID_Write and ID_EX_bubble SHALL follow the REQ-011 hazard rule.
REQ-014 flush=1 SHALL force the next state to IDLE with cnt=0 and SHALL take priority over md_start; md_done SHALL NOT pulse for an aborted op.
REQ-015 Priority SHALL be: reset > flush > state transition > md_start.
REQ-016 md_start while in MD_BUSY SHALL be ignored, since ID/EX is held.

Reset
REQ-017 On reset the block SHALL set state=IDLE, cnt=0 and stall_cycles=0; outputs SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_bubble=0 (hazard inputs permitting), EX_hold=0, md_busy=0, md_done=0.
REQ-018 Reset asserted mid-MD_BUSY SHALL abort the op with no md_done pulse.

Configuration
REQ-019 With EX_STALL_PERF_EN defined, stall_cycles SHALL increment (saturating at 2^32-1) on every cycle where PCWrite=0; without it, stall_cycles SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-020 The state encoding typedef and the MUL_LAT/DIV_LAT default constants SHALL live in the shared pipeline package.
REQ-021 The hazard compare SHALL be a sub-module, hazard_detect, which is purely combinational and instantiated once.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load rt=5 in ID/EX with if_id_rs=5 -> PCWrite=0 and ID_EX_bubble=1 for exactly 1 cycle.
- Load rt=0 with if_id_rs=0 -> no stall.
- md_start with md_is_div=0 (MUL_LAT=4) -> md_busy for 3 cycles, md_done at cycle 4, stall_cycles=3 with EX_STALL_PERF_EN.
- md_start with md_is_div=1, then flush at busy cycle 10 -> IDLE next cycle, md_done never asserts.
- Divide completes with md_start in MD_DONE -> new op starts, md_busy re-asserts on the next cycle.
- Reset at busy cycle 2 -> all outputs at reset values the following cycle, stall_cycles=0.
